// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter: FSM states and transaction owner.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_bus_watchdog.sv
// Cycle counter that flags a bus transaction stuck for TIMEOUT cycles.
// Instantiated by mem_bus_arbiter only when ARB_TIMEOUT_EN is defined.
module mem_bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Fires during the TIMEOUT-th busy cycle; the arbiter leaves the busy states then.
  assign expired_o = run_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (run_i && !expired_o) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing the memory bus between fetch (IF) and LSU.
// Optional watchdog timeout enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_err,
  output logic                mem_stall,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SC_W   = $clog2(STARVE_MAX + 1);

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  logic                killed_q, killed_d;
  logic [SC_W-1:0]     starve_q, starve_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;

  logic idle, busy, force_if, lsu_win, if_win;
  logic rsp_ok, timeout, resp, resp_err;

  assign idle     = (state_q == ARB_IDLE);
  assign busy     = !idle;
  assign force_if = if_req && (starve_q == SC_W'(STARVE_MAX));
  assign lsu_win  = idle && lsu_req && !force_if;
  assign if_win   = idle && !lsu_win && if_req && !if_kill;

`ifdef ARB_TIMEOUT_EN
  mem_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .run_i     (busy),
    .expired_o (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = busy && (TIMEOUT != 0);
  assign timeout = 1'b0;
`endif

  // A real bus response takes precedence over a watchdog expiry in the same cycle.
  assign rsp_ok   = (state_q == ARB_WAIT) && bus_rvalid;
  assign resp     = rsp_ok || timeout;
  assign resp_err = timeout && !rsp_ok;

  assign if_gnt     = if_win;
  assign lsu_gnt    = lsu_win;
  assign bus_req    = (state_q == ARB_REQ) && !timeout;
  assign if_rvalid  = resp && (owner_q == OWN_IF) && !(killed_q || if_kill);
  assign lsu_rvalid = resp && (owner_q == OWN_LSU);
  assign if_rdata   = resp_err ? '0 : bus_rdata;
  assign lsu_rdata  = resp_err ? '0 : bus_rdata;
  assign mem_stall  = lsu_req && !lsu_rvalid;

`ifdef ARB_TIMEOUT_EN
  assign if_err  = if_rvalid && resp_err;
  assign lsu_err = lsu_rvalid && resp_err;
`else
  assign if_err  = 1'b0;
  assign lsu_err = 1'b0;
`endif

  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    killed_d    = killed_q;
    starve_d    = starve_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;

    if (!if_req)
      starve_d = '0;
    else if (lsu_win && (starve_q != SC_W'(STARVE_MAX)))
      starve_d = starve_q + SC_W'(1);
    else if (if_win)
      starve_d = '0;

    case (state_q)
      ARB_IDLE: begin
        if (lsu_win) begin
          state_d     = ARB_REQ;
          owner_d     = OWN_LSU;
          bus_we_d    = lsu_we;
          bus_addr_d  = lsu_addr;
          bus_wdata_d = lsu_wdata;
          bus_wstrb_d = lsu_wstrb;
        end else if (if_win) begin
          state_d     = ARB_REQ;
          owner_d     = OWN_IF;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
          bus_wstrb_d = '0;
        end
      end
      ARB_REQ: begin
        if (owner_q == OWN_IF && if_kill) killed_d = 1'b1;
        if (timeout)      state_d = ARB_IDLE;
        else if (bus_gnt) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (owner_q == OWN_IF && if_kill) killed_d = 1'b1;
        if (bus_rvalid || timeout) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    if (state_d == ARB_IDLE) killed_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      killed_q    <= 1'b0;
      starve_q    <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      killed_q    <= killed_d;
      starve_q    <= starve_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: arbitration table, directed corner sequences and
// a randomized run against a transaction-level reference model with a memory image.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_kill;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        lsu_req, lsu_we;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_gnt, lsu_rvalid, lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_stall;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, want);
  endtask

  task automatic zero_inputs();
    if_req = 0; if_addr = 0; if_kill = 0;
    lsu_req = 0; lsu_we = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wstrb = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; zero_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic nc();
    @(posedge clk); #1;
    bus_gnt = 0; bus_rvalid = 0;
  endtask

  // Accept on the first REQ cycle, respond on the next; ends at the response negedge.
  task automatic serve(input logic [31:0] d);
    nc(); bus_gnt = 1;
    @(negedge clk);
    nc(); bus_rvalid = 1; bus_rdata = d;
    @(negedge clk);
  endtask

  typedef struct {
    logic ifr, ifk, lr;
    logic e_ig, e_lg, e_stall;
  } vec_t;

  // Reference model state for the random run.
  bit          m_act, m_acc, m_own_lsu, m_kill, m_we;
  int          m_starve, m_age, m_dly;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [31:0] mem [16];

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t vt[6];
    rst = 1; zero_inputs();

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_gnts", {if_gnt, lsu_gnt}, 0);
    chk("rst_rvalids", {if_rvalid, lsu_rvalid, if_err, lsu_err}, 0);
    chk("rst_payload", {bus_we, bus_wstrb, bus_addr, bus_wdata}, 0);
    chk("rst_stall", mem_stall, 0);

    // Arbitration in IDLE with starvation counter at zero
    vt[0] = '{0, 0, 0, 0, 0, 0};
    vt[1] = '{1, 0, 0, 1, 0, 0};
    vt[2] = '{0, 0, 1, 0, 1, 1};
    vt[3] = '{1, 0, 1, 0, 1, 1};
    vt[4] = '{1, 1, 0, 0, 0, 0};
    vt[5] = '{1, 1, 1, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      if_req = vt[i].ifr; if_kill = vt[i].ifk; lsu_req = vt[i].lr;
      if_addr = 32'h40; lsu_addr = 32'h80;
      @(negedge clk);
      chk($sformatf("tbl%0d_if_gnt", i), if_gnt, vt[i].e_ig);
      chk($sformatf("tbl%0d_lsu_gnt", i), lsu_gnt, vt[i].e_lg);
      chk($sformatf("tbl%0d_stall", i), mem_stall, vt[i].e_stall);
    end

    // Load with best-case handshake
    do_reset();
    lsu_req = 1; lsu_addr = 32'h100;
    @(negedge clk);
    chk("ld_gnt", lsu_gnt, 1);
    chk("ld_stall0", mem_stall, 1);
    nc(); bus_gnt = 1;
    @(negedge clk);
    chk("ld_bus_req", bus_req, 1);
    chk("ld_bus_addr", bus_addr, 32'h100);
    chk("ld_bus_we", bus_we, 0);
    chk("ld_no_regnt", lsu_gnt, 0);
    nc();
    @(negedge clk);
    chk("ld_wait_req", bus_req, 0);
    chk("ld_wait_rv", lsu_rvalid, 0);
    chk("ld_stall2", mem_stall, 1);
    nc(); bus_rvalid = 1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("ld_rvalid", lsu_rvalid, 1);
    chk("ld_rdata", lsu_rdata, 32'hDEADBEEF);
    chk("ld_if_rv", if_rvalid, 0);
    chk("ld_stall3", mem_stall, 0);
    nc(); lsu_req = 0;
    @(negedge clk);
    chk("ld_rv_pulse", lsu_rvalid, 0);

    // Simultaneous requests: LSU first, IF on the next IDLE
    do_reset();
    if_req = 1; if_addr = 32'h40; lsu_req = 1; lsu_addr = 32'h100;
    @(negedge clk);
    chk("sim_lsu_first", {if_gnt, lsu_gnt}, 2'b01);
    nc(); lsu_req = 0; bus_gnt = 1;
    @(negedge clk);
    chk("sim_busy_if", if_gnt, 0);
    nc(); bus_rvalid = 1; bus_rdata = 32'h11;
    @(negedge clk);
    chk("sim_bubble_if", if_gnt, 0);
    chk("sim_lsu_rv", lsu_rvalid, 1);
    nc();
    @(negedge clk);
    chk("sim_if_second", if_gnt, 1);
    nc(); if_req = 0; bus_gnt = 1;
    @(negedge clk);
    chk("sim_if_addr", bus_addr, 32'h40);
    nc(); bus_rvalid = 1; bus_rdata = 32'h55;
    @(negedge clk);
    chk("sim_if_rv", if_rvalid, 1);
    chk("sim_if_rdata", if_rdata, 32'h55);
    chk("sim_lsu_rv_off", lsu_rvalid, 0);

    // Starvation: four LSU wins, then IF forced; counter restarts from zero
    do_reset();
    if_req = 1; if_addr = 32'h80; lsu_req = 1; lsu_addr = 32'h10;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk($sformatf("stv%0d_lsu%0d", r, k), {if_gnt, lsu_gnt}, 2'b01);
        serve(32'h0);
        nc();
      end
      @(negedge clk);
      chk($sformatf("stv%0d_if", r), {if_gnt, lsu_gnt}, 2'b10);
      serve(32'h0);
      nc();
    end

    // Killed fetch completes on the bus without if_rvalid
    do_reset();
    if_req = 1; if_addr = 32'h200;
    @(negedge clk);
    chk("kill_gnt", if_gnt, 1);
    nc(); if_req = 0; bus_gnt = 1;
    @(negedge clk);
    chk("kill_addr", bus_addr, 32'h200);
    nc(); if_kill = 1;
    @(negedge clk);
    chk("kill_wait_rv", if_rvalid, 0);
    nc(); if_kill = 0; bus_rvalid = 1; bus_rdata = 32'h1234;
    @(negedge clk);
    chk("kill_suppr", if_rvalid, 0);
    chk("kill_lsu_rv", lsu_rvalid, 0);
    nc(); lsu_req = 1; lsu_addr = 32'h100;
    @(negedge clk);
    chk("kill_next_gnt", lsu_gnt, 1);
    serve(32'hABCD);
    chk("kill_next_rv", lsu_rvalid, 1);
    chk("kill_next_rd", lsu_rdata, 32'hABCD);

    // Store with a slow bus: payload held while bus_gnt is low
    do_reset();
    lsu_req = 1; lsu_we = 1; lsu_addr = 32'h300; lsu_wdata = 32'hCAFEF00D; lsu_wstrb = 4'b0011;
    @(negedge clk);
    chk("st_gnt", lsu_gnt, 1);
    nc(); lsu_addr = 32'h999; lsu_wdata = 0; lsu_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("st_hold%0d", i),
          {bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata[23:0]},
          {1'b1, 1'b1, 4'b0011, 32'h300, 24'hFEF00D});
      chk($sformatf("st_stall%0d", i), {lsu_gnt, mem_stall}, 2'b01);
      nc();
    end
    bus_gnt = 1;
    @(negedge clk);
    chk("st_req_at_gnt", bus_req, 1);
    nc(); bus_rvalid = 1;
    @(negedge clk);
    chk("st_ack", lsu_rvalid, 1);
    chk("st_stall_end", mem_stall, 0);
    nc(); lsu_req = 0; lsu_we = 0;

    // Reset while waiting for a response
    do_reset();
    lsu_req = 1; lsu_addr = 32'h100;
    @(negedge clk);
    nc(); lsu_req = 0; bus_gnt = 1;
    @(negedge clk);
    nc(); rst = 1;
    @(negedge clk);
    nc(); rst = 0;
    @(negedge clk);
    chk("rstw_outputs",
        {bus_req, if_gnt, lsu_gnt, if_rvalid, lsu_rvalid, if_err, lsu_err, mem_stall}, 0);
    chk("rstw_payload", {bus_we, bus_addr}, 0);

`ifdef ARB_TIMEOUT_EN
    // Bus never accepts: watchdog completes the load with an error
    do_reset();
    lsu_req = 1; lsu_addr = 32'h100; bus_rdata = 32'hFFFF;
    @(negedge clk);
    chk("to_gnt", lsu_gnt, 1);
    nc(); lsu_req = 0; bus_rdata = 32'hFFFF;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("to_busy%0d", i), {bus_req, lsu_rvalid}, 2'b10);
      nc(); bus_rdata = 32'hFFFF;
    end
    @(negedge clk);
    chk("to_fire", {lsu_rvalid, lsu_err, bus_req}, 3'b110);
    chk("to_rdata", lsu_rdata, 0);
    nc(); bus_rvalid = 1;
    @(negedge clk);
    chk("to_late_ignored", {lsu_rvalid, lsu_err}, 0);
    nc();
`endif

    // Randomized run against the reference model
    do_reset();
    m_act = 0; m_acc = 0; m_own_lsu = 0; m_kill = 0; m_we = 0;
    m_starve = 0; m_age = 0; m_dly = 0;
    m_addr = 0; m_wdata = 0; m_rdata = 0; m_wstrb = 0;
    for (int i = 0; i < 16; i++) mem[i] = 0;
    begin
      logic n_ifr, n_ifk, n_lr, n_lwe, n_bg, n_brv;
      logic [31:0] n_ifa, n_la, n_lwd, n_brd;
      logic [3:0] n_lws;
      n_ifr = 0; n_ifk = 0; n_lr = 0; n_lwe = 0; n_bg = 0; n_brv = 0;
      n_ifa = 0; n_la = 0; n_lwd = 0; n_brd = 0; n_lws = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        logic e_lw, e_iw, e_breq, rsp, e_ifrv, e_lrv;
        @(posedge clk); #1;
        if_req = n_ifr; if_addr = n_ifa; if_kill = n_ifk;
        lsu_req = n_lr; lsu_we = n_lwe; lsu_addr = n_la; lsu_wdata = n_lwd; lsu_wstrb = n_lws;
        bus_gnt = n_bg; bus_rvalid = n_brv; bus_rdata = n_brd;
        @(negedge clk);
        e_lw   = !m_act && lsu_req && !(if_req && m_starve == 4);
        e_iw   = !m_act && !e_lw && if_req && !if_kill;
        e_breq = m_act && !m_acc;
        rsp    = m_acc && bus_rvalid;
        e_ifrv = rsp && !m_own_lsu && !(m_kill || if_kill);
        e_lrv  = rsp && m_own_lsu;
        chk("rnd_if_gnt", if_gnt, e_iw);
        chk("rnd_lsu_gnt", lsu_gnt, e_lw);
        chk("rnd_bus_req", bus_req, e_breq);
        if (e_breq) begin
          chk("rnd_bus_addr", bus_addr, m_addr);
          chk("rnd_bus_we", bus_we, m_we);
          if (m_own_lsu) chk("rnd_bus_wr", {bus_wstrb, bus_wdata}, {m_wstrb, m_wdata});
        end
        chk("rnd_if_rv", if_rvalid, e_ifrv);
        chk("rnd_lsu_rv", lsu_rvalid, e_lrv);
        if (e_ifrv) chk("rnd_if_rdata", if_rdata, m_rdata);
        if (e_lrv && !m_we) chk("rnd_lsu_rdata", lsu_rdata, m_rdata);
        chk("rnd_stall", mem_stall, lsu_req && !e_lrv);
        chk("rnd_err", {if_err, lsu_err}, 0);

        if (m_act) begin
          if (!m_own_lsu && if_kill) m_kill = 1;
          if (!m_acc) begin
            if (bus_gnt) begin m_acc = 1; m_dly = $urandom_range(0, 2); end
            else m_age++;
          end else if (bus_rvalid) begin
            if (m_we)
              for (int b = 0; b < 4; b++)
                if (m_wstrb[b]) mem[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
            m_act = 0;
          end else m_dly--;
        end
        if (!if_req) m_starve = 0;
        else if (e_lw) m_starve = (m_starve < 4) ? m_starve + 1 : 4;
        else if (e_iw) m_starve = 0;
        if (e_lw || e_iw) begin
          m_act = 1; m_acc = 0; m_kill = 0; m_age = 0; m_own_lsu = e_lw;
          m_addr = e_lw ? lsu_addr : if_addr;
          m_we = e_lw && lsu_we;
          m_wdata = lsu_wdata; m_wstrb = lsu_wstrb;
        end

        if (e_iw || !if_req) begin
          n_ifr = ($urandom_range(0, 2) == 0);
          n_ifa = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        end
        n_ifk = ($urandom_range(0, 7) == 0);
        if (e_lw || !lsu_req) begin
          n_lr  = ($urandom_range(0, 2) == 0);
          n_lwe = $urandom_range(0, 1) == 1;
          n_la  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
          n_lwd = $urandom;
          n_lws = 4'($urandom_range(1, 15));
        end
        n_bg  = m_act && !m_acc && ($urandom_range(0, 1) == 1 || m_age >= 2);
        n_brv = m_act && m_acc && (m_dly == 0);
        n_brd = $urandom;
        if (n_brv && !m_we) n_brd = mem[m_addr[5:2]];
        m_rdata = n_brd;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
